// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU result types, widths and flag bit positions used by
//             the ALU and by alu_result_buffer.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_FLAG_W = 5;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ARITH = 1;
  localparam int FLG_LOGIC = 2;
  localparam int FLG_CMP   = 3;
  localparam int FLG_SHIFT = 4;

  typedef struct packed {
    logic [ALU_FLAG_W-1:0] flags;
    logic [ALU_DATA_W-1:0] data;
  } alu_result_t;

  // Gather the individual ALU flag lines into the canonical flag vector
  function automatic logic [ALU_FLAG_W-1:0] pack_flags(
    input logic carry,
    input logic arith,
    input logic logic_f,
    input logic cmp,
    input logic shift
  );
    logic [ALU_FLAG_W-1:0] f;
    f            = '0;
    f[FLG_CARRY] = carry;
    f[FLG_ARITH] = arith;
    f[FLG_LOGIC] = logic_f;
    f[FLG_CMP]   = cmp;
    f[FLG_SHIFT] = shift;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_buf_mem.sv
`default_nettype none
// ============================================================================
//  Module   : alu_buf_mem
//  Brief    : DEPTH x WIDTH register array, one synchronous write port and
//             one asynchronous read port. Contents are not reset.
//  Revision : 1.0  initial release
// ============================================================================
module alu_buf_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of each entry: only the addressed entry takes the write data
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (waddr == AW'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Storage registers; no reset because contents are don't-care when empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_buffer
//  Brief    : Show-ahead FIFO capturing ALU results and flags, presented to a
//             consumer with valid/ready. Never stalls the ALU: results that
//             arrive while full are dropped and flagged in sticky OVF.
//             Optional macro ALU_BUF_STATS_EN adds DROP_CNT and HWM outputs.
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  Carry_Flag,
  input  logic                  Arith_Flag,
  input  logic                  Logic_Flag,
  input  logic                  CMP_Flag,
  input  logic                  Shift_Flag,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ALU_FLAG_W-1:0] OUT_FLAGS,
  output logic [CNT_W-1:0]      COUNT,
  output logic                  FULL,
  output logic                  OVF,
  input  logic                  OVF_CLR
`ifdef ALU_BUF_STATS_EN
  ,
  output logic [15:0]           DROP_CNT,
  output logic [CNT_W-1:0]      HWM
`endif
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               ENT_W   = ALU_FLAG_W + DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic             full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;

  // Occupancy decode; a pop frees a slot in the same cycle so a full
  // buffer can still accept a result while the consumer drains it
  assign full      = (count_q == DEPTH_C);
  assign not_empty = (count_q != '0);
  assign pop       = not_empty & OUT_READY;
  assign push      = IN_VALID & (~full | pop);
  assign drop      = IN_VALID & full & ~pop;

  assign wr_entry  = {pack_flags(Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag),
                      ALU_OUT};

  // Pointer, occupancy and sticky-overflow next state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A drop in the clearing cycle must not be lost, so set beats clear
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  alu_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign OUT_VALID = not_empty;
  assign OUT_DATA  = rd_entry[DATA_WIDTH-1:0];
  assign OUT_FLAGS = rd_entry[ENT_W-1:DATA_WIDTH];
  assign COUNT     = count_q;
  assign FULL      = full;
  assign OVF       = ovf_q;

`ifdef ALU_BUF_STATS_EN
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] hwm_q,      hwm_d;

  // Saturating drop counter and occupancy high-water mark; a clear
  // restarts both from the state this edge leaves behind
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (OVF_CLR) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (OVF_CLR) begin
      drop_cnt_d = 16'd0;
    end
    hwm_d = hwm_q;
    if (OVF_CLR) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  // Statistics registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      hwm_q      <= hwm_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
  assign HWM      = hwm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_buffer
//  Brief    : Directed self-checking bench for alu_result_buffer (DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic [15:0] ALU_OUT;
  logic        Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_DATA;
  logic [4:0]  OUT_FLAGS;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        OVF;
  logic        OVF_CLR;
`ifdef ALU_BUF_STATS_EN
  logic [15:0] DROP_CNT;
  logic [2:0]  HWM;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_result_buffer #(
    .DATA_WIDTH (16),
    .DEPTH      (4),
    .CNT_W      (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .ALU_OUT    (ALU_OUT),
    .Carry_Flag (Carry_Flag),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_FLAGS  (OUT_FLAGS),
    .COUNT      (COUNT),
    .FULL       (FULL),
    .OVF        (OVF),
    .OVF_CLR    (OVF_CLR)
`ifdef ALU_BUF_STATS_EN
    ,
    .DROP_CNT   (DROP_CNT),
    .HWM        (HWM)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push1(input logic [15:0] d, input logic [4:0] f);
    IN_VALID = 1'b1;
    ALU_OUT  = d;
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag, Carry_Flag} = f;
    cyc();
    IN_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp3 [4];
    int          sent;
    int          got;
    logic        do_push;
    logic        full_m;
    logic        pop_m;

    RST = 1'b0; IN_VALID = 1'b0; ALU_OUT = '0; OUT_READY = 1'b0; OVF_CLR = 1'b0;
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag, Carry_Flag} = 5'b0;
    #12;
    check("rst_valid", OUT_VALID, 0);
    check("rst_count", COUNT, 0);
    check("rst_full",  FULL, 0);
    check("rst_ovf",   OVF, 0);
    @(negedge CLK);
    RST = 1'b1;

    // Single result, then hold, then accept
    push1(16'h1234, 5'b00011);
    check("one_valid", OUT_VALID, 1);
    check("one_data",  OUT_DATA, 16'h1234);
    check("one_flags", OUT_FLAGS, 5'b00011);
    check("one_count", COUNT, 1);
    cyc();
    check("hold_data", OUT_DATA, 16'h1234);
    check("hold_valid", OUT_VALID, 1);
    OUT_READY = 1'b1;
    cyc();
    OUT_READY = 1'b0;
    check("pop_valid", OUT_VALID, 0);
    check("pop_count", COUNT, 0);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) push1(16'(i), 5'(i));
    check("fill_full",  FULL, 1);
    check("fill_count", COUNT, 4);
    check("fill_ovf",   OVF, 0);
`ifdef ALU_BUF_STATS_EN
    OVF_CLR = 1'b1;
    cyc();
    OVF_CLR = 1'b0;
    check("st_clr_drop", DROP_CNT, 0);
    check("st_clr_hwm",  HWM, 4);
    for (int i = 0; i < 3; i++) push1(16'hDD00 + 16'(i), 5'b0);
    check("st_drop3", DROP_CNT, 3);
    check("st_hwm4",  HWM, 4);
`endif
    push1(16'd5, 5'b00101);
    check("ovf_set",   OVF, 1);
    check("ovf_count", COUNT, 4);
    check("ovf_full",  FULL, 1);
    OVF_CLR = 1'b1;
    push1(16'd6, 5'b00110);
    OVF_CLR = 1'b0;
    check("ovf_setwins", OVF, 1);
    check("ovf_count2",  COUNT, 4);
`ifdef ALU_BUF_STATS_EN
    check("st_clr_with_drop", DROP_CNT, 1);
`endif
    for (int i = 1; i <= 4; i++) begin
      check("drain_data",  OUT_DATA, 16'(i));
      check("drain_flags", OUT_FLAGS, 5'(i));
      OUT_READY = 1'b1;
      cyc();
      OUT_READY = 1'b0;
    end
    check("drain_valid", OUT_VALID, 0);
    check("drain_count", COUNT, 0);
    check("ovf_sticky",  OVF, 1);
    OVF_CLR = 1'b1;
    cyc();
    OVF_CLR = 1'b0;
    check("ovf_clr", OVF, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) push1(16'h0011 + 16'(i), 5'b01000);
    check("fp_full", FULL, 1);
    IN_VALID = 1'b1; ALU_OUT = 16'h0009; OUT_READY = 1'b1;
    cyc();
    IN_VALID = 1'b0;
    check("fp_count", COUNT, 4);
    check("fp_ovf",   OVF, 0);
    check("fp_head",  OUT_DATA, 16'h0012);
    exp3[0] = 16'h0012; exp3[1] = 16'h0013; exp3[2] = 16'h0014; exp3[3] = 16'h0009;
    for (int j = 0; j < 4; j++) begin
      check("fp_drain", OUT_DATA, exp3[j]);
      cyc();
    end
    OUT_READY = 1'b0;
    check("fp_empty", OUT_VALID, 0);

    // Wrap-around stream with toggling ready, checked against a queue model
    sent = 0;
    got  = 0;
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag, Carry_Flag} = 5'b10000;
    for (int c = 0; c < 24; c++) begin
      do_push   = (sent < 10) && ((c % 3) != 2);
      IN_VALID  = do_push;
      ALU_OUT   = 16'h0100 + 16'(sent);
      OUT_READY = c[0];
      check("wrap_valid", OUT_VALID, (q.size() != 0) ? 1 : 0);
      full_m = (q.size() == 4);
      pop_m  = (q.size() != 0) && OUT_READY;
      if (pop_m) begin
        check("wrap_data", OUT_DATA, q[0]);
        void'(q.pop_front());
        got++;
      end
      if (do_push) begin
        if (!full_m || pop_m) q.push_back(ALU_OUT);
        sent++;
      end
      cyc();
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    check("wrap_got",  got, 10);
    check("wrap_left", q.size(), 0);
    check("wrap_ovf",  OVF, 0);

    // Asynchronous reset mid-stream with OVF set and three entries held
    for (int i = 0; i < 4; i++) push1(16'h0021 + 16'(i), 5'b0);
    push1(16'h0025, 5'b0);
    OUT_READY = 1'b1;
    cyc();
    OUT_READY = 1'b0;
    check("pre_rst_count", COUNT, 3);
    check("pre_rst_ovf",   OVF, 1);
    #3;
    RST = 1'b0;
    #1;
    check("arst_valid", OUT_VALID, 0);
    check("arst_count", COUNT, 0);
    check("arst_ovf",   OVF, 0);
    check("arst_full",  FULL, 0);
    @(negedge CLK);
    RST = 1'b1;
    push1(16'hBEEF, 5'b10100);
    check("post_rst_data",  OUT_DATA, 16'hBEEF);
    check("post_rst_flags", OUT_FLAGS, 5'b10100);
    check("post_rst_count", COUNT, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 16-bit ALU: captures each registered ALU result and its five flags into a small FIFO.
- Presents the captured entries to a consumer through a valid/ready handshake.
- The ALU cannot stall, so this block never back-pressures it. Results arriving while the buffer is full are dropped and counted.
- Sits between the ALU output registers and the writeback/bus interface.

Parameters:
- DATA_WIDTH, 16, width of ALU_OUT and OUT_DATA.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of COUNT.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  high for one cycle when ALU_OUT and the flags hold a new result (issued cycle after the ALU command).
- ALU_OUT  in  DATA_WIDTH  ALU result.
- Carry_Flag  in  1  ALU carry.
- Arith_Flag  in  1  ALU arithmetic-class flag.
- Logic_Flag  in  1  ALU logic-class flag.
- CMP_Flag  in  1  ALU compare-class flag.
- Shift_Flag  in  1  ALU shift-class flag.
- OUT_VALID  out  1  head entry available.
- OUT_READY  in  1  consumer accepts the head entry.
- OUT_DATA  out  DATA_WIDTH  head result.
- OUT_FLAGS  out  5  head flags: bit0 Carry, bit1 Arith, bit2 Logic, bit3 CMP, bit4 Shift.
- COUNT  out  CNT_W  occupancy, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH.
- OVF  out  1  sticky: at least one result was dropped.
- OVF_CLR  in  1  synchronous clear of OVF.

Behaviour:
- Reset (RST low, asynchronous): pointers = 0, COUNT = 0, OUT_VALID = 0, FULL = 0, OVF = 0. OUT_DATA and OUT_FLAGS read storage; storage contents are don't-care after reset.
- push = IN_VALID and (not FULL, or pop). pop = OUT_VALID and OUT_READY.
- Each entry stores {flags, ALU_OUT} exactly as sampled on the push edge. No arithmetic or modification is applied.
- Show-ahead: OUT_DATA/OUT_FLAGS always reflect the entry at the read pointer. OUT_VALID = (COUNT != 0).
- Latency: a result pushed on edge N is visible with OUT_VALID = 1 in the cycle after edge N. There is no same-cycle bypass from input to output.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- COUNT update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Empty and IN_VALID with OUT_READY: push only. The pop is ignored because OUT_VALID = 0.
- Full with IN_VALID and pop in the same cycle: both occur. No drop; COUNT stays DEPTH.
- Full with IN_VALID and no pop: the result is discarded, OVF is set on that edge, and the stored entries are unchanged.
- OUT_VALID high with OUT_READY low: the head entry and outputs hold stable until accepted.
- OVF_CLR in the same cycle as a new drop: the set wins and OVF = 1.
- RST asserted mid-operation: all entries are discarded immediately. OUT_VALID drops asynchronously.
- No FSM beyond the pointer/count datapath. The single state is the occupancy (EMPTY, PARTIAL, FULL), derived from COUNT.

Optional Feature:
- Macro: ALU_BUF_STATS_EN.
- When defined, the block adds two outputs:
  - DROP_CNT [15:0]: increments on every dropped result, saturates at 16'hFFFF, and is cleared by OVF_CLR. If a drop and OVF_CLR occur in the same cycle, DROP_CNT = 1.
  - HWM [CNT_W-1:0]: high-water mark of COUNT. Reset value 0; cleared by OVF_CLR to the current COUNT.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALU_DATA_W = 16.
  - ALU_FLAG_W = 5.
  - Flag bit index constants FLG_CARRY=0, FLG_ARITH=1, FLG_LOGIC=2, FLG_CMP=3, FLG_SHIFT=4.
  - A packed result typedef {flags, data} used by the ALU and this block.
- One sub-module: alu_buf_mem, a DEPTH x (DATA_WIDTH+5) register array with one write port and one asynchronous read port. Control, pointers, count and the OVF/stats logic stay in the top.

Test Plan:
- Reset then single result: IN_VALID with ALU_OUT=16'h1234 and flags=5'b00011, OUT_READY=0.
  - Next cycle: OUT_VALID=1, OUT_DATA=16'h1234, OUT_FLAGS=5'b00011, COUNT=1.
  - Raise OUT_READY: the following cycle has OUT_VALID=0 and COUNT=0.
- Fill and overflow (DEPTH=4): push 1,2,3,4 with OUT_READY=0, so FULL=1.
  - Push 5: OVF=1, COUNT=4.
  - Drain: outputs 1,2,3,4 in order; 5 never appears.
- Full with simultaneous push/pop: FULL, IN_VALID(9) and OUT_READY=1.
  - No drop, OVF unchanged, COUNT=4.
  - Last entry drained is 9.
- Wrap-around: stream 10 results with OUT_READY toggling every cycle.
  - All 10 emerge in order with no loss; pointers wrap at least twice.
- Async reset mid-stream: with COUNT=3, pull RST low between clock edges.
  - OUT_VALID=0, COUNT=0 and OVF=0 immediately.
  - First push after release is the first entry out.
- With ALU_BUF_STATS_EN, in the full state:
  - 3 drops give DROP_CNT=3 and HWM=4.
  - OVF_CLR together with a drop gives OVF=1 and DROP_CNT=1.
